multicycle_control: RTL and testbench

Controller for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). The block is a Moore FSM that sequences a shared datapath with one memory port, the instruction register, the old-PC and data registers, the ALU-output register and the register file. It generates per-cycle mux selects and write enables, and derives ALUControl from the existing aludec. A memory-ready handshake stretches the memory-access states.

---
 rtl/multicycle_control_pkg.sv | 127 ++++++++++++
 rtl/aludec.sv | 29 ++
 rtl/mc_mainfsm.sv | 71 +++++++
 rtl/multicycle_control.sv | 70 +++++++
 tb/tb_multicycle_control.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// datapath select codes and the per-state control word.
package multicycle_control_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MREAD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MWRITE = 4'd5,
        S_EXECR  = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXECI  = 4'd8,
        S_JAL    = 4'd9,
        S_BEQ    = 4'd10
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_update;
        logic       rdy_gate;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word; unreachable encodings get FETCH selects with no enables.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.rdy_gate   = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: begin
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps ALUOp and the instruction function fields to ALUControl.
module aludec (
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] alu_op_i,
    output logic [2:0] alu_control_o
);
    import multicycle_control_pkg::*;

    always_comb begin
        alu_control_o = 3'b000;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = 3'b000;
            ALUOP_SUB: alu_control_o = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // sub only for R-type with funct7b5; addi never subtracts
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_o = 3'b101;
                    3'b110:  alu_control_o = 3'b011;
                    3'b111:  alu_control_o = 3'b010;
                    default: alu_control_o = 3'b000;
                endcase
            end
            default: alu_control_o = 3'b000;
        endcase
    end
endmodule

// File: rtl/mc_mainfsm.sv
// Main controller FSM: state register, next-state logic and registered
// Moore control word (computed from the next state so it aligns with it).
module mc_mainfsm
    import multicycle_control_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] op_i,
    input  logic       rdy_i,
    output logic [3:0] state_o,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);
    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   op_ok;

    always_comb begin
        op_ok = (op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_R) ||
                (op_i == OP_I)  || (op_i == OP_BEQ) || (op_i == OP_JAL);
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = rdy_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_i == OP_LW) ? S_MREAD : S_MWRITE;
            S_MREAD:  state_d = rdy_i ? S_MEMWB : S_MREAD;
            S_MEMWB:  state_d = S_FETCH;
            S_MWRITE: state_d = rdy_i ? S_FETCH : S_MWRITE;
            S_EXECR:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_EXECI:  state_d = S_ALUWB;
            S_JAL:    state_d = S_ALUWB;
            S_BEQ:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    // An upset into an unused encoding must not fire any enable.
    always_comb begin
        ctrl_o = ctrl_q;
        if (state_q > S_BEQ) begin
            ctrl_o = state_ctrl(state_q);
        end
    end

    assign state_o   = state_q;
    assign illegal_o = (state_q == S_DECODE) && !op_ok;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I controller top: main FSM, ALU decoder, ImmSrc decode,
// ready gating of FETCH enables and the PCWrite combine.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       IllegalInstr,
    output logic [3:0] State
);
    ctrl_t ctrl;
    logic  rdy;
    logic  gate;
    logic  illegal;
    logic  pc_update;

    assign rdy = MemReady | ~WAIT_EN;

    mc_mainfsm u_fsm (
        .clk_i     (clk),
        .reset_i   (reset),
        .op_i      (op),
        .rdy_i     (rdy),
        .state_o   (State),
        .ctrl_o    (ctrl),
        .illegal_o (illegal)
    );

    aludec u_aludec (
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_op_i      (ctrl.alu_op),
        .alu_control_o (ALUControl)
    );

    // FETCH enables wait for memory; MWRITE keeps its strobe up while stalled.
    assign gate      = ~ctrl.rdy_gate | rdy;
    assign pc_update = ctrl.pc_update & gate;

    assign PCWrite      = ~reset & (pc_update | (ctrl.branch & Zero));
    assign IRWrite      = ~reset & ctrl.ir_write & gate;
    assign MemWrite     = ~reset & ctrl.mem_write;
    assign RegWrite     = ~reset & ctrl.reg_write;
    assign IllegalInstr = ~reset & illegal;

    assign AdrSrc    = ctrl.adr_src;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ImmSrc    = imm_src(op);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction runs, a reset abort and
// random instruction streams, checked against an instruction-level model.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic       w_PCWrite, w_AdrSrc, w_MemWrite, w_IRWrite, w_RegWrite, w_IllegalInstr;
    logic [1:0] w_ResultSrc, w_ALUSrcA, w_ALUSrcB, w_ImmSrc;
    logic [2:0] w_ALUControl;
    logic [3:0] w_State;

    int checks = 0;
    int errors = 0;
    bit rdy_q[$];

    typedef struct packed {
        logic       adr;
        logic       mw;
        logic       rw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
    } exp_t;

    logic [6:0] opc_tab[7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h73};
    logic [2:0] f3_tab[4]  = '{3'b000, 3'b010, 3'b110, 3'b111};

    multicycle_control #(.WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .IllegalInstr(IllegalInstr), .State(State)
    );

    multicycle_control #(.WAIT_EN(1'b0)) dut_nowait (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(w_PCWrite), .AdrSrc(w_AdrSrc),
        .MemWrite(w_MemWrite), .IRWrite(w_IRWrite), .ResultSrc(w_ResultSrc),
        .ALUControl(w_ALUControl), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB),
        .ImmSrc(w_ImmSrc), .RegWrite(w_RegWrite), .IllegalInstr(w_IllegalInstr), .State(w_State)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-state select/enable values as tabulated for the controller.
    function automatic exp_t exp_tab(input int s);
        exp_t e;
        e = '0;
        case (s)
            0:  begin e.res = 2'b10; e.sb = 2'b10; end
            1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            3:  e.adr = 1'b1;
            4:  begin e.res = 2'b01; e.rw = 1'b1; end
            5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            6:  e.sa = 2'b10;
            7:  e.rw = 1'b1;
            8:  begin e.sa = 2'b10; e.sb = 2'b01; end
            9:  begin e.sa = 2'b01; e.sb = 2'b10; end
            10: e.sa = 2'b10;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [2:0] m_alu(input int s);
        if (s == 10) return 3'b001;
        if (s == 6 || s == 8) begin
            case (funct3)
                3'b000:  return (op[5] && funct7b5) ? 3'b001 : 3'b000;
                3'b010:  return 3'b101;
                3'b110:  return 3'b011;
                3'b111:  return 3'b010;
                default: return 3'b000;
            endcase
        end
        return 3'b000;
    endfunction

    function automatic logic [1:0] m_imm();
        if (op == 7'h23) return 2'b01;
        if (op == 7'h63) return 2'b10;
        if (op == 7'h6F) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic m_illegal(input int s);
        return (s == 1) && !(op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F});
    endfunction

    task automatic check_cycle(input int s, input logic r);
        exp_t e;
        logic pcw;
        e   = exp_tab(s);
        pcw = ((s == 0) && r) || (s == 9) || ((s == 10) && Zero);
        chk("State", 8'(State), 8'(s));
        chk("AdrSrc", 8'(AdrSrc), 8'(e.adr));
        chk("MemWrite", 8'(MemWrite), 8'(e.mw));
        chk("RegWrite", 8'(RegWrite), 8'(e.rw));
        chk("ResultSrc", 8'(ResultSrc), 8'(e.res));
        chk("ALUSrcA", 8'(ALUSrcA), 8'(e.sa));
        chk("ALUSrcB", 8'(ALUSrcB), 8'(e.sb));
        chk("IRWrite", 8'(IRWrite), 8'((s == 0) && r));
        chk("PCWrite", 8'(PCWrite), 8'(pcw));
        chk("ALUControl", 8'(ALUControl), 8'(m_alu(s)));
        chk("ImmSrc", 8'(ImmSrc), 8'(m_imm()));
        chk("IllegalInstr", 8'(IllegalInstr), 8'(m_illegal(s)));
    endtask

    // Runs one instruction from FETCH; classes: 0 lw 1 sw 2 R 3 I 4 beq 5 jal 6 illegal.
    task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                             input logic z, input bit rnd);
        int   seq[$];
        int   waits;
        bit   stretch;
        logic r;
        op = opc_tab[cls]; funct3 = f3; funct7b5 = f7; Zero = z;
        case (cls)
            0:       seq = '{0, 1, 2, 3, 4};
            1:       seq = '{0, 1, 2, 5};
            2:       seq = '{0, 1, 6, 7};
            3:       seq = '{0, 1, 8, 7};
            4:       seq = '{0, 1, 10};
            5:       seq = '{0, 1, 9, 7};
            default: seq = '{0, 1};
        endcase
        foreach (seq[i]) begin
            waits   = 0;
            stretch = (seq[i] == 0) || (seq[i] == 3) || (seq[i] == 5);
            do begin
                if (stretch) begin
                    if (rdy_q.size() > 0) r = rdy_q.pop_front();
                    else if (rnd)         r = ($urandom_range(0, 3) != 0);
                    else                  r = 1'b1;
                    if (waits >= 4) r = 1'b1;
                end else begin
                    r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                MemReady = r;
                @(negedge clk);
                check_cycle(seq[i], r);
                @(posedge clk); #1;
                waits++;
            end while (stretch && !r);
        end
    endtask

    initial begin
        int nw_seq[6];
        reset = 1'b1; op = 7'h03; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b1; MemReady = 1'b1;

        @(negedge clk);
        chk("rst_State", 8'(State), 8'd0);
        chk("rst_IRWrite", 8'(IRWrite), 8'd0);
        chk("rst_PCWrite", 8'(PCWrite), 8'd0);
        chk("rst_ALUSrcB", 8'(ALUSrcB), 8'd2);
        chk("rst_ResultSrc", 8'(ResultSrc), 8'd2);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(0, 3'b010, 1'b0, 1'b0, 1'b0);
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_instr(1, 3'b010, 1'b0, 1'b0, 1'b0);
        run_instr(4, 3'b000, 1'b0, 1'b1, 1'b0);
        run_instr(4, 3'b000, 1'b0, 1'b0, 1'b0);
        run_instr(2, 3'b000, 1'b1, 1'b0, 1'b0);
        run_instr(3, 3'b000, 1'b1, 1'b0, 1'b0);
        run_instr(5, 3'b000, 1'b0, 1'b0, 1'b0);
        run_instr(6, 3'b000, 1'b0, 1'b0, 1'b0);

        // lw abandoned by an asynchronous reset while stalled in MREAD
        op = 7'h03; MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_walk", 8'(State), 8'(i));
            @(posedge clk); #1;
        end
        MemReady = 1'b0;
        @(negedge clk);
        chk("abort_mread", 8'(State), 8'd3);
        #2 reset = 1'b1; MemReady = 1'b1;
        #1;
        chk("abort_State", 8'(State), 8'd0);
        chk("abort_IRWrite", 8'(IRWrite), 8'd0);
        chk("abort_PCWrite", 8'(PCWrite), 8'd0);
        chk("abort_RegWrite", 8'(RegWrite), 8'd0);
        chk("abort_MemWrite", 8'(MemWrite), 8'd0);
        chk("abort_AdrSrc", 8'(AdrSrc), 8'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        run_instr(0, 3'b000, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 50; n++) begin
            run_instr($urandom_range(0, 6), f3_tab[$urandom_range(0, 3)],
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        // WAIT_EN=0 instance ignores a stuck-low MemReady
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; MemReady = 1'b0; op = 7'h03;
        nw_seq = '{0, 1, 2, 3, 4, 0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("nowait_State", 8'(w_State), 8'(nw_seq[i]));
            chk("nowait_IRWrite", 8'(w_IRWrite), 8'(nw_seq[i] == 0));
            chk("nowait_RegWrite", 8'(w_RegWrite), 8'(nw_seq[i] == 4));
            chk("nowait_ResultSrc", 8'(w_ResultSrc), 8'(nw_seq[i] == 4 ? 1 : (nw_seq[i] == 0 ? 2 : 0)));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
